// File: rtl/pheap_frontend.sv
// Command front-end for pipelined-heap level 0: admits LEQ/DEQ/CLEAR requests,
// enforces occupancy and issue spacing, and holds dequeued results for the client.
module pheap_frontend #(
  parameter int LEVELS       = 4,
  parameter int ISSUE_GAP    = 2,
  parameter int RSP_LAT      = 1,
  parameter int CLEAR_CYCLES = LEVELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_value,
  output logic [33:0]       l0_op,
  input  logic              l0_rsp_valid,
  input  logic [31:0]       l0_rsp_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_value,
  output logic [LEVELS-1:0] count,
  output logic              err_full,
  output logic              err_empty
);

  // states:
  //   IDLE     | ready for a new client request
  //   GAP      | spacing out level-0 issues after an op
  //   WAIT_RSP | DEQ issued, waiting for the popped root
  //   CLEARING | CLEAR issued, letting it ripple through the levels
  typedef enum logic [1:0] {IDLE, GAP, WAIT_RSP, CLEARING} state_t;

  localparam logic [1:0] OP_FREE  = 2'd0;
  localparam logic [1:0] OP_LEQ   = 2'd1;
  localparam logic [1:0] OP_DEQ   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int TMAX     = (ISSUE_GAP > CLEAR_CYCLES) ? ISSUE_GAP : CLEAR_CYCLES;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int POST_GAP = (RSP_LAT >= ISSUE_GAP - 1) ? 0 : (ISSUE_GAP - 1 - RSP_LAT);

  localparam logic [LEVELS-1:0] CAP = {LEVELS{1'b1}};

  state_t state, state_next;

  logic [TW-1:0]     timer, timer_d;
  logic [33:0]       l0_op_d;
  logic [LEVELS-1:0] count_d;
  logic              rsp_valid_d;
  logic [31:0]       rsp_value_d;
  logic              err_full_d, err_empty_d;
  logic              accept;

  assign req_ready = !rst && (state == IDLE) && (timer == '0) && !rsp_valid;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_LEQ:   if (count != CAP) state_next = (ISSUE_GAP > 1) ? GAP : IDLE;
            OP_DEQ:   if (count != '0)  state_next = WAIT_RSP;
            OP_CLEAR: state_next = CLEARING;
            default:  state_next = IDLE;
          endcase
        end
      end
      GAP:      if (timer <= TW'(1)) state_next = IDLE;
      WAIT_RSP: if (l0_rsp_valid) state_next = (POST_GAP > 0) ? GAP : IDLE;
      CLEARING: if (timer <= TW'(1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    l0_op_d     = {OP_FREE, 32'd0};
    count_d     = count;
    timer_d     = timer;
    rsp_valid_d = rsp_valid;
    rsp_value_d = rsp_value;
    err_full_d  = 1'b0;
    err_empty_d = 1'b0;

    if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_LEQ: begin
              if (count != CAP) begin
                l0_op_d = {OP_LEQ, req_value};
                count_d = count + LEVELS'(1);
                timer_d = TW'(ISSUE_GAP - 1);
              end else begin
                err_full_d = 1'b1;
              end
            end
            OP_DEQ: begin
              if (count != '0) begin
                l0_op_d = {OP_DEQ, 32'd0};
                count_d = count - LEVELS'(1);
              end else begin
                err_empty_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              l0_op_d = {OP_CLEAR, 32'd0};
              count_d = '0;
              timer_d = TW'(CLEAR_CYCLES);
            end
            default: ;
          endcase
        end
      end
      GAP, CLEARING: timer_d = (timer <= TW'(1)) ? '0 : timer - TW'(1);
      WAIT_RSP: begin
        if (l0_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_value_d = l0_rsp_value;
          timer_d     = TW'(POST_GAP);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l0_op     <= {OP_FREE, 32'd0};
      count     <= '0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_value <= '0;
      err_full  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      l0_op     <= l0_op_d;
      count     <= count_d;
      timer     <= timer_d;
      rsp_valid <= rsp_valid_d;
      rsp_value <= rsp_value_d;
      err_full  <= err_full_d;
      err_empty <= err_empty_d;
    end
  end

endmodule

// File: tb/tb_pheap_frontend.sv
// Directed bench for pheap_frontend: linear steps with hand-computed expectations.
module tb_pheap_frontend;

  localparam logic [1:0] FREE = 2'd0, LEQ = 2'd1, DEQ = 2'd2, CLR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_value;
  logic [33:0] l0_op;
  logic        l0_rsp_valid;
  logic [31:0] l0_rsp_value;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_value;
  logic [3:0]  count;
  logic        err_full;
  logic        err_empty;

  int n_tests = 0;
  int n_fail  = 0;

  pheap_frontend dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_value(req_value),
    .l0_op(l0_op), .l0_rsp_valid(l0_rsp_valid), .l0_rsp_value(l0_rsp_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
    .count(count), .err_full(err_full), .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("%s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_checks(input string tag, input logic [3:0] exp_count);
    chk({tag, "_l0op"}, 64'(l0_op), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(exp_count));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = FREE; req_value = '0;
    l0_rsp_valid = 1'b0; l0_rsp_value = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_l0op", 64'(l0_op), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rspv", 64'(rsp_valid), 64'(0));
    chk("rst_rspval", 64'(rsp_value), 64'(0));
    chk("rst_errf", 64'(err_full), 64'(0));
    chk("rst_erre", 64'(err_empty), 64'(0));
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(req_ready), 64'(1));

    // single LEQ 0x10
    req_valid = 1'b1; req_op = LEQ; req_value = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("leq_l0op", 64'(l0_op), {30'd0, LEQ, 32'h10});
    chk("leq_count", 64'(count), 64'(1));
    chk("leq_gap_ready", 64'(req_ready), 64'(0));
    tick();
    chk("leq_ready_back", 64'(req_ready), 64'(1));
    idle_checks("leq_after", 4'd1);

    // fill from empty, then one more
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 1'b1; req_op = LEQ;
    for (int i = 1; i <= 15; i++) begin
      req_value = 32'(i);
      tick();
      chk("fill_l0op", 64'(l0_op), {30'd0, LEQ, 32'(i)});
      tick();
      chk("fill_gap_free", 64'(l0_op), 64'(0));
    end
    chk("fill_count", 64'(count), 64'(15));
    chk("fill_ready", 64'(req_ready), 64'(1));
    req_value = 32'h99;
    tick();
    req_valid = 1'b0;
    chk("full_err", 64'(err_full), 64'(1));
    idle_checks("full", 4'd15);
    chk("full_ready", 64'(req_ready), 64'(1));
    tick();
    chk("full_err_pulse", 64'(err_full), 64'(0));

    // DEQ with held response
    req_valid = 1'b1; req_op = DEQ;
    tick();
    req_valid = 1'b0;
    chk("deq_l0op", 64'(l0_op), {30'd0, DEQ, 32'd0});
    chk("deq_count", 64'(count), 64'(14));
    chk("deq_wait_ready", 64'(req_ready), 64'(0));
    l0_rsp_valid = 1'b1; l0_rsp_value = 32'h5;
    tick();
    l0_rsp_valid = 1'b0; l0_rsp_value = '0;
    for (int k = 0; k < 3; k++) begin
      chk("rsp_hold_v", 64'(rsp_valid), 64'(1));
      chk("rsp_hold_val", 64'(rsp_value), 64'(5));
      chk("rsp_hold_ready", 64'(req_ready), 64'(0));
      chk("rsp_hold_l0op", 64'(l0_op), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_clear", 64'(rsp_valid), 64'(0));
    chk("rsp_ready_back", 64'(req_ready), 64'(1));
    chk("rsp_count", 64'(count), 64'(14));

    // stray level-0 response while idle
    l0_rsp_valid = 1'b1; l0_rsp_value = 32'h77;
    tick();
    l0_rsp_valid = 1'b0;
    chk("stray_rspv", 64'(rsp_valid), 64'(0));

    // DEQ at empty
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 1'b1; req_op = DEQ;
    tick();
    req_valid = 1'b0;
    chk("empty_err", 64'(err_empty), 64'(1));
    idle_checks("empty", 4'd0);
    tick();
    chk("empty_err_pulse", 64'(err_empty), 64'(0));

    // 3 LEQs then CLEAR
    req_valid = 1'b1; req_op = LEQ;
    for (int i = 0; i < 3; i++) begin
      req_value = 32'hA + 32'(i);
      tick(); tick();
    end
    chk("pre_clr_count", 64'(count), 64'(3));
    req_op = CLR;
    tick();
    req_valid = 1'b0;
    chk("clr_l0op", 64'(l0_op), {30'd0, CLR, 32'd0});
    chk("clr_count", 64'(count), 64'(0));
    chk("clr_ready1", 64'(req_ready), 64'(0));
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("clr_ready_low", 64'(req_ready), 64'(0));
      chk("clr_l0op_free", 64'(l0_op), 64'(0));
    end
    tick();
    chk("clr_ready_back", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = DEQ;
    tick();
    req_valid = 1'b0;
    chk("clr_deq_err", 64'(err_empty), 64'(1));
    chk("clr_deq_l0op", 64'(l0_op), 64'(0));

    // reset during WAIT_RSP
    tick();
    req_valid = 1'b1; req_op = LEQ; req_value = 32'h21;
    tick(); tick();
    req_op = DEQ;
    tick();
    req_valid = 1'b0;
    chk("mid_deq_l0op", 64'(l0_op), {30'd0, DEQ, 32'd0});
    rst = 1'b1;
    tick();
    chk("mid_rst_l0op", 64'(l0_op), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    l0_rsp_valid = 1'b1; l0_rsp_value = 32'h55;
    tick();
    l0_rsp_valid = 1'b0;
    chk("mid_rspv", 64'(rsp_valid), 64'(0));
    chk("mid_rspval", 64'(rsp_value), 64'(0));
    chk("mid_ready", 64'(req_ready), 64'(1));
    chk("mid_count", 64'(count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pheap_frontend.md
Name: pheap_frontend

Overview:
- Command front-end sitting directly upstream of pipelined-heap level 0.
- Accepts enqueue (LEQ), dequeue (DEQ) and clear (CLEAR) requests from the client on a valid/ready interface.
- Enforces occupancy limits and the level-0 issue spacing, then drives one opArray_t per cycle into level 0.
- Captures the dequeued root value returned by level 0 and presents it to the client on a held response interface.

Parameters:
- LEVELS, 4: heap depth, from pheapTypes. Capacity is 2^LEVELS-1 = 15 entries.
- ISSUE_GAP, 2: minimum cycles between consecutive non-FREE ops issued to level 0. Must be >= 1.
- RSP_LAT, 1: cycles from DEQ issue until level 0 asserts l0_rsp_valid.
- CLEAR_CYCLES, LEVELS: cycles the block waits after issuing CLEAR before accepting requests again.

Ports:
- clk  input  1  sole clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  client request valid.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  2  opcode_t. FREE on a handshake is ignored.
- req_value  input  32  pValue to enqueue. Don't-care unless req_op is LEQ.
- l0_op  output  34  opArray_t {levelOp, priorityValue} driven to level 0.
- l0_rsp_valid  input  1  level 0 has the popped root value.
- l0_rsp_value  input  32  popped root value.
- rsp_valid  output  1  dequeue result held for the client.
- rsp_ready  input  1  client consumes the result.
- rsp_value  output  32  dequeued value.
- count  output  LEVELS  current committed occupancy.
- err_full  output  1  one-cycle pulse: LEQ rejected because the heap is full.
- err_empty  output  1  one-cycle pulse: DEQ rejected because the heap is empty.

Behaviour:
- Reset (synchronous, rst high at the clock edge): state=IDLE, l0_op={FREE,0}, req_ready=0 during rst, rsp_valid=0, rsp_value=0, count=0, err_full=0, err_empty=0, gap counter=0.
- l0_op is registered. It is FREE in every cycle except the single cycle after an accepted, forwarded request.
- Handshake: a request transfers when req_valid && req_ready. req_ready is combinational from state only, with no dependence on req_valid.
- req_ready=1 only when all of the following hold: state=IDLE, the gap counter is 0, and rsp_valid=0.
- States:
  - IDLE:
    - LEQ with count<15: issue {LEQ,req_value}, count+1, then go to GAP.
    - LEQ with count=15: drop it, pulse err_full, stay in IDLE, no op issued.
    - DEQ with count>0: issue {DEQ,0}, count-1, then go to WAIT_RSP.
    - DEQ with count=0: drop it, pulse err_empty, stay in IDLE.
    - CLEAR: issue {CLEAR,0}, count=0, load the wait counter with CLEAR_CYCLES, then go to CLEARING.
    - FREE: no effect.
  - GAP: hold for ISSUE_GAP-1 cycles after an issue, then return to IDLE. With ISSUE_GAP=1, GAP is skipped.
  - WAIT_RSP:
    - On l0_rsp_valid: capture l0_rsp_value into rsp_value, set rsp_valid=1.
    - Then go to GAP, or to IDLE if RSP_LAT >= ISSUE_GAP-1.
    - l0_rsp_valid outside WAIT_RSP is ignored.
  - CLEARING:
    - Decrement the wait counter. At 0, return to IDLE.
    - If rsp_valid is set on entry, it stays set. CLEAR does not discard a result the client has not consumed.
- Response: rsp_valid and rsp_value hold until rsp_ready is high. rsp_valid clears on that edge. While rsp_valid=1 no new request is accepted.
- Simultaneous events:
  - A capture and rsp_ready in the same cycle cannot occur, because rsp_valid=0 is required to issue the DEQ.
  - An error pulse and a request accept never coincide with an issue.
- count never wraps. The full and empty checks use count as it was before the request.
- rst asserted mid-operation (GAP, WAIT_RSP or CLEARING) returns every register to its reset value on that edge.
  - Any in-flight l0_rsp_valid after reset is ignored.
  - Level 0 is reset on the same rst.

Test Plan:
- Reset then single LEQ 0x10 → l0_op={LEQ,0x10} for exactly one cycle, count=1. req_ready is low for ISSUE_GAP-1=1 cycle after the issue, then high.
- 15 back-to-back LEQs, values 1..15, then a 16th LEQ 0x99 → count=15. The 16th request is accepted, err_full pulses for 1 cycle, l0_op stays FREE.
- DEQ with a level-0 model returning 0x5 after 1 cycle, with rsp_ready held low 3 cycles → rsp_valid=1 and rsp_value=0x5 for all 3 cycles, req_ready=0 throughout. rsp_valid clears the cycle rsp_ready rises. count decrements by 1.
- DEQ at count=0 → err_empty pulses for 1 cycle, no DEQ issued, count stays 0.
- 3 LEQs, then CLEAR → l0_op={CLEAR,0}, count=0, req_ready=0 for CLEAR_CYCLES=4 cycles. A subsequent DEQ pulses err_empty.
- rst pulsed during WAIT_RSP, with l0_rsp_valid asserted the next cycle → all outputs return to reset values and rsp_valid stays 0.
